// File: rtl/code_group_aligner.sv
// 1000BASE-X receive comma aligner: shifts in one bit per clock, locks the
// 10-bit boundary to the comma and strobes aligned code groups out on PUDI.
module code_group_aligner #(
  parameter int MIS_THRESH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bit,
  output logic [9:0] rx_code_group,
  output logic       PUDI,
  output logic       comma,
  output logic       aligned,
  output logic       realign
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [2:0] MIS_LAST = 3'(MIS_THRESH - 1);

  state_t      state, state_nx;
  logic [9:0]  sr;
  logic [3:0]  ph, ph_nx;
  logic        primed;
  logic [2:0]  mis_cnt, mis_nx;
  logic        comma_now;
  logic        emit;
  logic        realign_nx;

  assign comma_now = primed && ((sr[9:3] == 7'b0011111) || (sr[9:3] == 7'b1100000));
  assign aligned   = (state == LOCKED);

  always_comb begin
    state_nx   = state;
    emit       = 1'b0;
    realign_nx = 1'b0;
    mis_nx     = mis_cnt;
    // Saturating at 9 is harmless in LOCKED because ph==9 always emits there.
    ph_nx      = (ph == 4'd9) ? ph : ph + 4'd1;
    unique case (state)
      HUNT: begin
        if (comma_now) begin
          emit     = 1'b1;
          mis_nx   = '0;
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (ph == 4'd9) begin
          emit = 1'b1;
          if (comma_now) mis_nx = '0;
        end else if (comma_now) begin
          if (mis_cnt == MIS_LAST) begin
            emit       = 1'b1;
            realign_nx = 1'b1;
            mis_nx     = '0;
          end else begin
            mis_nx = mis_cnt + 3'd1;
          end
        end
      end
      default: state_nx = HUNT;
    endcase
    if (emit) ph_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HUNT;
      sr            <= '0;
      ph            <= '0;
      primed        <= 1'b0;
      mis_cnt       <= '0;
      rx_code_group <= '0;
      PUDI          <= 1'b0;
      comma         <= 1'b0;
      realign       <= 1'b0;
    end else begin
      state   <= state_nx;
      sr      <= {sr[8:0], rx_bit};
      ph      <= ph_nx;
      // ph only reaches 9 unprimed after nine edges, so this sets primed on the tenth.
      primed  <= primed | (ph == 4'd9);
      mis_cnt <= mis_nx;
      PUDI    <= emit;
      comma   <= emit & comma_now;
      realign <= realign_nx;
      if (emit) rx_code_group <= sr;
    end
  end

endmodule

// File: tb/tb_code_group_aligner.sv
// Bench for code_group_aligner: bit-history reference model checked every
// cycle, plus literal expectations for lock latency, slips and resets.
module tb_code_group_aligner;

  localparam int T = 3;
  localparam logic [9:0] K285 = 10'b0011111010;
  localparam logic [9:0] D162 = 10'b1001000101;
  localparam logic [9:0] D215 = 10'b1010101010;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_bit;
  logic [9:0] rx_code_group;
  logic       PUDI, comma, aligned, realign;

  always #5 clk = ~clk;

  code_group_aligner #(.MIS_THRESH(T)) dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit),
    .rx_code_group(rx_code_group), .PUDI(PUDI), .comma(comma),
    .aligned(aligned), .realign(realign)
  );

  // Reference model: full bit history since reset, boundary = bit count at last emit.
  bit         hist[$];
  int         n;
  bit         m_locked;
  int         m_mis;
  int         m_last_end;
  logic [9:0] e_cg;
  logic       e_pudi, e_comma, e_realign;

  int total = 0, passed = 0;
  int pudi_cnt = 0, realign_cnt = 0, first_pudi_n = -1;
  logic [9:0] first_cg, realign_cg;
  logic       first_comma, first_aligned;

  function automatic logic [9:0] window();
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[9-i] = hist[n-10+i];
    return w;
  endfunction

  task automatic model_step();
    logic [9:0] w;
    bit c;
    bit emit;
    w = '0; c = 0; emit = 0;
    if (rst) begin
      hist.delete();
      n = 0; m_locked = 0; m_mis = 0; m_last_end = 0;
      e_cg = '0; e_pudi = 0; e_comma = 0; e_realign = 0;
    end else begin
      if (n >= 10) begin
        w = window();
        c = (w[9:3] == 7'b0011111) || (w[9:3] == 7'b1100000);
      end
      e_realign = 0;
      if (!m_locked) begin
        if (c) begin emit = 1; m_locked = 1; m_mis = 0; end
      end else if (n - m_last_end == 10) begin
        emit = 1;
        if (c) m_mis = 0;
      end else if (c) begin
        if (m_mis < T - 1) m_mis++;
        else begin emit = 1; e_realign = 1; m_mis = 0; end
      end
      e_pudi  = emit;
      e_comma = emit && c;
      if (emit) begin e_cg = w; m_last_end = n; end
      hist.push_back(rx_bit);
      n++;
    end
  endtask

  task automatic compare();
    total++;
    if ({rx_code_group, PUDI, comma, aligned, realign} ===
        {e_cg, e_pudi, e_comma, m_locked, e_realign})
      passed++;
    else
      $display("FAIL cycle_compare n=%0d got cg=%b pudi=%b comma=%b aligned=%b realign=%b expected cg=%b pudi=%b comma=%b aligned=%b realign=%b",
               n, rx_code_group, PUDI, comma, aligned, realign,
               e_cg, e_pudi, e_comma, m_locked, e_realign);
  endtask

  task automatic stats();
    if (n == 0) first_pudi_n = -1;
    if (PUDI === 1'b1) begin
      pudi_cnt++;
      if (first_pudi_n < 0) begin
        first_pudi_n  = n;
        first_cg      = rx_code_group;
        first_comma   = comma;
        first_aligned = aligned;
      end
    end
    if (realign === 1'b1) begin
      realign_cnt++;
      realign_cg = rx_code_group;
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
    stats();
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  task automatic send_bit(input logic b);
    rx_bit = b;
    tick();
  endtask

  task automatic send_group(input logic [9:0] g, input int nb);
    for (int i = 0; i < nb; i++) send_bit(g[9-i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_bit = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_pairs(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      send_group(K285, 10);
      send_group(D162, 10);
    end
  endtask

  initial begin
    int bp, br;
    logic [9:0] rg;
    rst = 1'b1;
    rx_bit = 1'b0;

    // 1: lock on a stream offset by three junk bits
    do_reset();
    check("reset_outputs", int'({rx_code_group, PUDI, comma, aligned, realign}), 0);
    bp = pudi_cnt; br = realign_cnt;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_pairs(10);
    check("lock_first_pudi_edge", first_pudi_n, 14);
    check("lock_first_group", int'(first_cg), int'(K285));
    check("lock_first_comma", int'(first_comma), 1);
    check("lock_first_aligned", int'(first_aligned), 1);
    check("lock_pudi_count", pudi_cnt - bp, 19);
    check("lock_no_realign", realign_cnt - br, 0);

    // 2: comma-free data never locks
    do_reset();
    bp = pudi_cnt;
    for (int i = 0; i < 20; i++) send_group(($urandom_range(0, 1) == 0) ? D162 : D215, 10);
    check("nocomma_pudi_count", pudi_cnt - bp, 0);
    check("nocomma_aligned", int'(aligned), 0);

    // 3: one dropped bit realigns on the third misaligned comma
    do_reset();
    send_pairs(4);
    br = realign_cnt;
    send_group(D162, 9);
    send_pairs(8);
    check("slip_realign_count", realign_cnt - br, 1);
    check("slip_realign_group", int'(realign_cg), int'(K285));

    // 4: an aligned comma clears the misaligned count
    do_reset();
    send_pairs(4);
    br = realign_cnt;
    send_group(D162, 9); send_group(K285, 10); send_bit(1'b1);
    send_pairs(3);
    send_group(D162, 9); send_group(K285, 10);
    send_group(D162, 10); send_group(K285, 10); send_bit(1'b1);
    send_pairs(4);
    check("misclear_no_realign", realign_cnt - br, 0);
    check("misclear_aligned", int'(aligned), 1);

    // 5: reset while locked, then relock at the earliest legal edge
    do_reset();
    send_pairs(3);
    check("pre_reset_aligned", int'(aligned), 1);
    do_reset();
    check("midreset_outputs", int'({rx_code_group, PUDI, comma, aligned, realign}), 0);
    send_pairs(3);
    check("relock_first_pudi_edge", first_pudi_n, 11);
    check("relock_first_group", int'(first_cg), int'(K285));
    check("relock_first_comma", int'(first_comma), 1);

    // 6: a comma formed with the reset zeros must not be detected
    do_reset();
    bp = pudi_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    check("prime_no_pudi", pudi_cnt - bp, 0);
    check("prime_not_aligned", int'(aligned), 0);

    // Randomized traffic with slips, junk and occasional resets
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      rg = 10'($urandom);
      if (r < 7) send_group(K285, 10);
      else if (r < 12) send_group(D162, 10);
      else if (r < 14) send_group(D215, 10);
      else if (r < 16) send_group(rg, 10);
      else if (r < 19) send_group(rg, int'($urandom_range(1, 9)));
      else do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/code_group_aligner.md
# code_group_aligner

Serial-to-parallel comma aligner for the 1000BASE-X PCS receive path, directly upstream of the clause 36 synchronization block. It shifts in one received bit per clock and searches for the 7-bit comma pattern. It locks the 10-bit code-group boundary to the comma, then presents aligned code groups on `rx_code_group` with a one-cycle `PUDI` strobe. Those two outputs feed the synchronizer's `rx_code_group` and `PUDI` inputs.

## Interface

Parameters:
- `MIS_THRESH`, default 3: number of consecutive misaligned commas seen while locked that forces a realign. Legal range is 1..7.

Ports:
- `clk`  input  1: single clock. All logic is on the rising edge.
- `rst`  input  1: reset. It is **synchronous and active-high**.
- `rx_bit`  input  1: received serial bit, one new bit every clock. Bit `a` of each code group arrives first.
- `rx_code_group`  output  10: aligned code group. Bit [9] is the first-received bit (`a`); bit [0] is the last (`j`).
- `PUDI`  output  1: one-cycle strobe marking that `rx_code_group` holds a new group.
- `comma`  output  1: high together with `PUDI` when the emitted group's bits [9:3] are a comma.
- `aligned`  output  1: high while in state LOCKED.
- `realign`  output  1: one-cycle pulse when the boundary is moved while LOCKED.

## Operation

Internal registers:
- `sr[9:0]`: shift register. Every cycle `sr <= {sr[8:0], rx_bit}`.
- `ph[3:0]`: bits since the last boundary, range 0..9.
- `primed`: set once 10 bits have been shifted in since reset.
- `mis_cnt[2:0]`: count of consecutive misaligned commas.

Comma detection:
- `comma_now` = `primed` & (`sr[9:3]` == 7'b0011111 | `sr[9:3]` == 7'b1100000).
- Before `primed` is set, a comma is never detected. This blocks false hits on the reset zeros.

Emit action (shared by every state):
- At the next edge, load `rx_code_group <= sr`, `PUDI <= 1`, `comma <= comma_now`, `ph <= 0`.
- When nothing is emitted, `PUDI <= 0` and `comma <= 0`, and `rx_code_group` holds its value.
- Outside an emit, `ph` increments each cycle and saturates at 9 in HUNT.

State machine:
- **HUNT** (entered from reset)
  - On `comma_now`: emit, clear `mis_cnt`, go to LOCKED.
  - Otherwise: no `PUDI`.
- **LOCKED**, cases evaluated per cycle:
  - `ph==9` & ~`comma_now`: emit (normal boundary).
  - `ph==9` & `comma_now`: aligned comma. Emit and clear `mis_cnt`.
  - `ph!=9` & `comma_now` & `mis_cnt < MIS_THRESH-1`: increment `mis_cnt`, no emit.
  - `ph!=9` & `comma_now` & `mis_cnt == MIS_THRESH-1`: realign.
    - Emit, pulse `realign`, clear `mis_cnt`.
    - The partial group in progress is discarded and no `PUDI` is produced for it.
    - The `PUDI` spacing across a realign may be shorter than 10 cycles.
- LOCKED never returns to HUNT except through `rst`. Loss of sync is the synchronizer's decision.

## Timing

- Reset value of every output is 0. Internal state on reset: `sr`=0, `ph`=0, `primed`=0, `mis_cnt`=0, state=HUNT.
- Reset has priority over all other events. `rst` high during LOCKED clears everything at that edge. `PUDI` is 0 in the following cycle.
- Latency: bit `j` of a group is sampled into `sr[0]` at edge N. The group appears on `rx_code_group` with `PUDI` high after edge N+1, i.e. one clock after its last bit is sampled.
- Steady state in LOCKED: `PUDI` is high exactly 1 cycle in every 10. `rx_code_group` is stable for the 10 cycles between strobes.
- `primed` becomes 1 at the 10th edge after reset release. The earliest possible first `PUDI` is therefore after edge 11.
- `realign` coincides with the emitting `PUDI`. `aligned` rises in the same cycle as the first `PUDI`.

## Test plan

1. **Lock on offset stream.** After reset, send 3 junk bits, then alternating K28.5 RD- (10'b0011111010) and D16.2 (10'b1001000101).
   - First `PUDI` carries 10'b0011111010 with `comma`=1 and `aligned`=1.
   - After that, `PUDI` repeats every 10 cycles with alternating correct groups and `realign` stays 0.
2. **No commas.** Send 200 cycles of comma-free D-groups after reset.
   - `PUDI`, `aligned` and `comma` stay 0 throughout.
3. **Bit slip with default `MIS_THRESH`=3.** While locked, drop one bit from the stream.
   - The first two misaligned commas produce no `realign`.
   - The third produces `realign`=1 with `PUDI` carrying 10'b0011111010.
   - Subsequent groups are decoded correctly at 10-cycle spacing.
4. **`mis_cnt` clear.** While locked, inject one misaligned comma, then resume aligned commas, then inject two more misaligned commas.
   - No `realign`, because the aligned comma cleared `mis_cnt`.
5. **Reset mid-stream.** Assert `rst` for 1 cycle while LOCKED.
   - All outputs are 0 in the next cycle.
   - Relock occurs no earlier than 11 edges after release and only on a comma.
6. **Priming guard.** Drive `rx_bit`=1 for 5 cycles immediately after reset, followed by 010.
   - No comma is detected and no `PUDI` occurs before `primed` is set.
